// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding and the counter-width helper.
package mul_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Ceiling log2; returns the bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Datapath for mul_seq: operand shift registers and the 2W accumulator-adder.
// Optional build macro MUL_SEQ_SIGNED_EN adds sign-magnitude handling.
module mul_seq_dp
  import mul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   y_i,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic           sgn_i,
`endif
  output logic [2*W-1:0] prod_c
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] mcand_q, mcand_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  xm_c, ym_c;
`ifdef MUL_SEQ_SIGNED_EN
  logic          neg_q, neg_d;
`endif

  // Operand magnitudes presented at capture time
  always_comb begin
`ifdef MUL_SEQ_SIGNED_EN
    xm_c = (sgn_i && x_i[W-1]) ? (W'(0) - x_i) : x_i;
    ym_c = (sgn_i && y_i[W-1]) ? (W'(0) - y_i) : y_i;
`else
    xm_c = x_i;
    ym_c = y_i;
`endif
  end

  // Load clears the accumulator; each step consumes one multiplier bit
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`ifdef MUL_SEQ_SIGNED_EN
    neg_d    = neg_q;
`endif
    if (load_i) begin
      mcand_d  = {{W{1'b0}}, xm_c};
      mplier_d = ym_c;
      acc_d    = '0;
`ifdef MUL_SEQ_SIGNED_EN
      neg_d    = sgn_i & (x_i[W-1] ^ y_i[W-1]);
`endif
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
`ifdef MUL_SEQ_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

`ifdef MUL_SEQ_SIGNED_EN
  assign prod_c = neg_q ? (PW'(0) - acc_q) : acc_q;
`else
  assign prod_c = acc_q;
`endif

endmodule

// File: rtl/mul_seq.sv
// Sequential W x W shift-add multiplier: FSM, bit counter and result register.
// Optional build macro MUL_SEQ_SIGNED_EN adds the sgn port (two's-complement mode).
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = clog2(W + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [PW-1:0] z_q, z_d;
  logic          load_c, step_c;
  logic [PW-1:0] prod_c;

  mul_seq_dp #(.W(W)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_c),
    .step_i (step_c),
    .x_i    (x),
    .y_i    (y),
`ifdef MUL_SEQ_SIGNED_EN
    .sgn_i  (sgn),
`endif
    .prod_c (prod_c)
  );

  // done and z are registered on the DONE->IDLE edge, so done lands W+1 edges after accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          cnt_d   = CW'(W);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        z_d     = prod_c;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;

endmodule
